// File: rtl/chan_fifo_if.sv
// Write-side valid/ready channel plus read-side pull port of chan_fifo.
// Signal names match the pull2chan port names so the read side wires straight across.
interface chan_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic [WIDTH-1:0]    idata;
  logic                ivalid;
  logic                iready;
  logic [WIDTH-1:0]    odata;
  logic                oempty;
  logic                orden;
  logic [DEPTH_LOG2:0] ocount;

  modport slave (
    input  idata, ivalid, orden,
    output iready, odata, oempty, ocount
  );

  modport master (
    output idata, ivalid, orden,
    input  iready, odata, oempty, ocount
  );
endinterface

// File: rtl/chan_fifo.sv
// Synchronous FIFO: valid/ready write channel in, empty/read-enable pull port out.
// Sustains one push and one pop per clock; oempty looks ahead past an in-flight read.
module chan_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input logic        clock,
  input logic        resetn,
  chan_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic                  iready_q;
  logic                  push, pop;

  assign push = bus.ivalid && iready_q;
  assign pop  = bus.orden && (count != '0);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  // iready is registered from the next count, so a pop at full only reopens
  // the write side one cycle later.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      iready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      iready_q <= (count_nxt < FULL);
    end
  end

  // Storage holds no reset: contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.idata;
  end

  // Head word is read straight from storage; rd_ptr only moves on a pop and
  // the head slot is only written when the queue is empty, so odata is stable
  // between those events.
  assign bus.odata  = mem[rd_ptr];
  assign bus.oempty = (count == '0) || ((count == {{DEPTH_LOG2{1'b0}}, 1'b1}) && bus.orden);
  assign bus.iready = iready_q;
  assign bus.ocount = count;
endmodule
